// File: rtl/uart_tx_driver.sv
// -----------------------------------------------------------------------------
// uart_tx_driver
//   UART transmitter (fixed 8N1, LSB first) fed by a byte FIFO. Intended to
//   drive a peripheral UART RX pin, either in simulation or as a host-side
//   stimulus source on FPGA. The bit period is CLK_FREQ_HZ / BAUD_RATE clocks.
//
// Ports
//   clk_i    in   1   system clock, rising edge
//   reset_i  in   1   synchronous reset, active-high
//   data_i   in   8   byte to queue
//   valid_i  in   1   data_i valid; written when valid_i && ready_o
//   ready_o  out  1   FIFO can accept a byte (not full)
//   tx_o     out  1   serial line, idle high, driven from a flop
//   busy_o   out  1   high while a frame occupies the line
//   count_o  out  $clog2(FIFO_DEPTH+1)  bytes queued, excluding the frame in flight
// -----------------------------------------------------------------------------
module uart_tx_driver #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [7:0]                         data_i,
    input  logic                               valid_i,
    output logic                               ready_o,
    output logic                               tx_o,
    output logic                               busy_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    // Guarded widths keep elaboration sane long enough for the checks below to fire.
    localparam int CNT_W = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam int AW    = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_chk_cpb
        $error("uart_tx_driver: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_chk_depth
        $error("uart_tx_driver: FIFO_DEPTH must be a power of two and >= 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  baud_cnt_q, baud_cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [7:0]        mem [FIFO_DEPTH];

    logic empty, full, push, pop, baud_last;

    always_comb begin
        // Pointers carry an extra wrap bit: equal means empty, equal index with
        // differing wrap bit means full.
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        push      = valid_i && !full;
        baud_last = (baud_cnt_q == CNT_LAST);

        state_d    = state_q;
        baud_cnt_d = baud_last ? '0 : baud_cnt_q + CNT_W'(1);
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        busy_d     = busy_q;
        pop        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                baud_cnt_d = '0;
                if (!empty) begin
                    pop       = 1'b1;
                    state_d   = ST_START;
                    busy_d    = 1'b1;
                    bit_idx_d = 3'd0;
                end
            end
            ST_START: begin
                if (baud_last) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (baud_last) begin
                    // Chaining straight into START keeps back-to-back frames gapless.
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (pop) begin
            shift_d = mem[rd_ptr_q[AW-1:0]];
        end

        // The line follows the registered state one clock later, so every bit
        // period is exactly CLKS_PER_BIT cycles long and tx_o is a plain flop.
        case (state_q)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_q[0];
            default:  tx_d = 1'b1;
        endcase

        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Control state: reset applies here only.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= 3'd0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Datapath storage: contents are don't-care until referenced by the pointers.
    always_ff @(posedge clk_i) begin
        shift_q <= shift_d;
        if (push && !reset_i) begin
            mem[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

    assign ready_o = !full;
    assign tx_o    = tx_q;
    assign busy_o  = busy_q;
    assign count_o = count_q;

endmodule

// File: tb/tb_uart_tx_driver.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_driver
//   Drives uart_tx_driver at 10 clocks per bit with a 4-entry FIFO. A schedule
//   model records when each accepted byte is popped (as soon as it is visible
//   and the previous frame's 10 bit periods are over) and derives the expected
//   line level, busy, count and ready for every clock from that schedule.
// -----------------------------------------------------------------------------
module tb_uart_tx_driver;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int CPB    = CLK_HZ / BAUD;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int FRAME  = 10 * CPB;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic [7:0]    data_i = 8'h00;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic          tx_o;
    logic          busy_o;
    logic [CW-1:0] count_o;

    uart_tx_driver #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD_RATE   (BAUD),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .tx_o    (tx_o),
        .busy_o  (busy_o),
        .count_o (count_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    // Schedule model: accept edge, pop edge and value of every byte since reset.
    int         acc_q[$];
    int         pop_q[$];
    logic [7:0] byte_q[$];

    function automatic int model_count(input int n);
        int c = 0;
        foreach (acc_q[k]) if (acc_q[k] <= n && pop_q[k] > n) c++;
        return c;
    endfunction

    function automatic logic model_busy(input int n);
        foreach (pop_q[k]) if (n >= pop_q[k] && n < pop_q[k] + FRAME) return 1'b1;
        return 1'b0;
    endfunction

    // Line level after edge n: start bit, 8 data bits LSB first, stop bit.
    function automatic logic model_tx(input int n);
        foreach (pop_q[k]) begin
            int f = pop_q[k] + 1;
            if (n >= f && n < f + FRAME) begin
                int j = (n - f) / CPB;
                logic [7:0] b = byte_q[k];
                if (j == 0) return 1'b0;
                if (j == 9) return 1'b1;
                return b[j-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic model_ready(input int n);
        return model_count(n) < DEPTH;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: compare outputs (state after edge cyc), apply inputs, take the
    // edge and update the model with what that edge does.
    task automatic step(input logic v, input logic [7:0] d);
        if (chk_en) begin
            check("tx",    {7'd0, tx_o},    {7'd0, model_tx(cyc)});
            check("busy",  {7'd0, busy_o},  {7'd0, model_busy(cyc)});
            check("ready", {7'd0, ready_o}, {7'd0, model_ready(cyc)});
            check("count", 8'(count_o),     8'(model_count(cyc)));
        end
        valid_i = v;
        data_i  = d;
        @(posedge clk);
        cyc++;
        if (reset_i) begin
            acc_q.delete();
            pop_q.delete();
            byte_q.delete();
        end else if (v && model_ready(cyc - 1)) begin
            int p = cyc + 1;
            if (pop_q.size() > 0 && pop_q[$] + FRAME > p) p = pop_q[$] + FRAME;
            acc_q.push_back(cyc);
            pop_q.push_back(p);
            byte_q.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    initial begin
        @(negedge clk);
        // Reset and long idle
        reset_i = 1'b1;
        idle(5);
        reset_i = 1'b0;
        chk_en  = 1'b1;
        idle(1000);

        // Single byte 0xA5
        step(1'b1, 8'hA5);
        idle(120);

        // Back-to-back frames
        step(1'b1, 8'h00);
        step(1'b1, 8'hFF);
        step(1'b1, 8'h55);
        idle(320);

        // Continuous push into a full FIFO; extra bytes are dropped
        for (int i = 0; i < 30; i++) step(1'b1, 8'($urandom));
        idle(600);

        // Reset during bit 3 of 0x3C with two bytes queued
        step(1'b1, 8'h3C);
        step(1'b1, 8'($urandom));
        step(1'b1, 8'($urandom));
        idle(42);
        reset_i = 1'b1;
        idle(1);
        reset_i = 1'b0;
        idle(300);

        // Random traffic
        for (int i = 0; i < 400; i++) step(($urandom % 4) == 0, 8'($urandom));
        idle(700);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
